// File: rtl/io_requester.sv
// rtl/io_requester.sv - CPU-side I/O initiator: level-held in/out requests,
// acknowledge wait with timeout, read capture, write hold and done pulse.
module io_requester #(
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        state,
  input  logic              io_rd,
  input  logic              io_wr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              in_signal,
  output logic              out_signal,
  input  logic              clocked_in_signal,
  input  logic              clocked_out_signal,
  input  logic [DATA_W-1:0] dev_rd_data,
  output logic [DATA_W-1:0] dev_wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              io_busy,
  output logic              io_done,
  output logic              io_timeout,
  output logic              io_collision,
  input  logic              err_clr
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0] CPU_EXEC = 3'b010;

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_WAIT_IN  = 2'd1;
  localparam logic [1:0] S_WAIT_OUT = 2'd2;
  localparam logic [1:0] S_COMPLETE = 2'd3;

  logic [1:0]        fsm_q, fsm_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              in_signal_q, in_signal_d;
  logic              out_signal_q, out_signal_d;
  logic              io_done_q, io_done_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic [DATA_W-1:0] dev_wr_data_q, dev_wr_data_d;
  logic              io_timeout_q, io_timeout_d;
  logic              io_collision_q, io_collision_d;
  logic              set_timeout, set_collision;
  logic              exec;

  assign exec = (state == CPU_EXEC);

  always_comb begin
    fsm_d         = fsm_q;
    cnt_d         = cnt_q;
    rd_data_d     = rd_data_q;
    dev_wr_data_d = dev_wr_data_q;
    set_timeout   = 1'b0;
    set_collision = 1'b0;

    case (fsm_q)
      S_IDLE: begin
        if (exec && io_rd) begin
          fsm_d         = S_WAIT_IN;
          cnt_d         = '0;
          set_collision = io_wr;
        end else if (exec && io_wr) begin
          fsm_d         = S_WAIT_OUT;
          cnt_d         = '0;
          dev_wr_data_d = wr_data;
        end
      end
      // Abort beats acknowledge; acknowledge beats timeout in the last cycle.
      S_WAIT_IN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (!exec) begin
          fsm_d = S_IDLE;
        end else if (clocked_in_signal) begin
          rd_data_d = dev_rd_data;
          fsm_d     = S_COMPLETE;
        end else if (cnt_q == CNT_LAST) begin
          set_timeout = 1'b1;
          fsm_d       = S_COMPLETE;
        end
      end
      S_WAIT_OUT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (!exec) begin
          fsm_d = S_IDLE;
        end else if (clocked_out_signal) begin
          fsm_d = S_COMPLETE;
        end else if (cnt_q == CNT_LAST) begin
          set_timeout = 1'b1;
          fsm_d       = S_COMPLETE;
        end
      end
      S_COMPLETE: fsm_d = S_IDLE;
      default:    fsm_d = S_IDLE;
    endcase

    io_timeout_d   = err_clr ? 1'b0 : (io_timeout_q | set_timeout);
    io_collision_d = err_clr ? 1'b0 : (io_collision_q | set_collision);

    // Request lines and done are decoded from the next state so they come straight off flops.
    in_signal_d  = (fsm_d == S_WAIT_IN);
    out_signal_d = (fsm_d == S_WAIT_OUT);
    io_done_d    = (fsm_d == S_COMPLETE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q          <= S_IDLE;
      cnt_q          <= '0;
      in_signal_q    <= 1'b0;
      out_signal_q   <= 1'b0;
      io_done_q      <= 1'b0;
      rd_data_q      <= '0;
      dev_wr_data_q  <= '0;
      io_timeout_q   <= 1'b0;
      io_collision_q <= 1'b0;
    end else begin
      fsm_q          <= fsm_d;
      cnt_q          <= cnt_d;
      in_signal_q    <= in_signal_d;
      out_signal_q   <= out_signal_d;
      io_done_q      <= io_done_d;
      rd_data_q      <= rd_data_d;
      dev_wr_data_q  <= dev_wr_data_d;
      io_timeout_q   <= io_timeout_d;
      io_collision_q <= io_collision_d;
    end
  end

  // Combinational so the CPU stalls in the very cycle it raises a request.
  assign io_busy = (fsm_q == S_WAIT_IN) || (fsm_q == S_WAIT_OUT) ||
                   ((fsm_q == S_IDLE) && exec && (io_rd || io_wr));

  assign in_signal    = in_signal_q;
  assign out_signal   = out_signal_q;
  assign io_done      = io_done_q;
  assign rd_data      = rd_data_q;
  assign dev_wr_data  = dev_wr_data_q;
  assign io_timeout   = io_timeout_q;
  assign io_collision = io_collision_q;

endmodule

// File: tb/tb_io_requester.sv
// tb/tb_io_requester.sv - scoreboard bench for io_requester with a registered
// device acknowledge model.
module tb_io_requester;

  localparam int DW = 8;

  typedef struct packed {
    logic          is_rd;
    logic          to;
    logic [DW-1:0] data;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [2:0]    state = 3'b000;
  logic          io_rd = 1'b0;
  logic          io_wr = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          in_signal, out_signal;
  logic          clocked_in_signal = 1'b0;
  logic          clocked_out_signal = 1'b0;
  logic [DW-1:0] dev_rd_data = '0;
  logic [DW-1:0] dev_wr_data, rd_data;
  logic          io_busy, io_done, io_timeout, io_collision;
  logic          err_clr = 1'b0;

  logic          dev_mute = 1'b0;
  logic          dev_force_in = 1'b0;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  io_requester #(.DATA_W(DW), .TIMEOUT_CYCLES(15)) dut (
    .clk(clk), .reset(reset), .state(state), .io_rd(io_rd), .io_wr(io_wr),
    .wr_data(wr_data), .in_signal(in_signal), .out_signal(out_signal),
    .clocked_in_signal(clocked_in_signal), .clocked_out_signal(clocked_out_signal),
    .dev_rd_data(dev_rd_data), .dev_wr_data(dev_wr_data), .rd_data(rd_data),
    .io_busy(io_busy), .io_done(io_done), .io_timeout(io_timeout),
    .io_collision(io_collision), .err_clr(err_clr)
  );

  // Device: acknowledge is the request registered once, so it trails the request by a cycle.
  always @(posedge clk) begin
    clocked_in_signal  <= (in_signal & ~dev_mute) | dev_force_in;
    clocked_out_signal <= out_signal & ~dev_mute;
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_done(input int max_cyc, output int cyc);
    cyc = 0;
    do begin
      step();
      cyc++;
    end while (!io_done && cyc <= max_cyc);
  endtask

  task automatic test_reset();
    exp_t e;
    reset = 1'b1;
    step();
    step();
    n_cmp++; if (in_signal !== 1'b0) begin n_bad++; $display("FAIL reset_in_signal got %b want 0", in_signal); end
    n_cmp++; if (out_signal !== 1'b0) begin n_bad++; $display("FAIL reset_out_signal got %b want 0", out_signal); end
    n_cmp++; if (rd_data !== 8'h00) begin n_bad++; $display("FAIL reset_rd_data got %h want 00", rd_data); end
    n_cmp++; if (dev_wr_data !== 8'h00) begin n_bad++; $display("FAIL reset_dev_wr_data got %h want 00", dev_wr_data); end
    n_cmp++; if ({io_done, io_timeout, io_collision, io_busy} !== 4'b0000) begin
      n_bad++; $display("FAIL reset_flags got %b want 0000", {io_done, io_timeout, io_collision, io_busy});
    end
    reset = 1'b0;
    state = 3'b010;
    step();
    n_cmp++; if (io_busy !== 1'b0) begin n_bad++; $display("FAIL idle_busy got %b want 0", io_busy); end
    e = '0;
    if (sb_q.size() != 0) e = sb_q.pop_front();
  endtask

  task automatic test_read();
    exp_t e;
    dev_rd_data = 8'hA5;
    sb_q.push_back({1'b1, 1'b0, 8'hA5});
    io_rd = 1'b1;
    #1;
    n_cmp++; if ({io_busy, in_signal} !== 2'b10) begin n_bad++; $display("FAIL rd_c0 busy/in got %b want 10", {io_busy, in_signal}); end
    step();
    n_cmp++; if ({io_busy, in_signal, io_done} !== 3'b110) begin n_bad++; $display("FAIL rd_c1 busy/in/done got %b want 110", {io_busy, in_signal, io_done}); end
    step();
    n_cmp++; if ({io_busy, in_signal, io_done} !== 3'b110) begin n_bad++; $display("FAIL rd_c2 busy/in/done got %b want 110", {io_busy, in_signal, io_done}); end
    step();
    n_cmp++; if ({io_busy, in_signal, io_done} !== 3'b001) begin n_bad++; $display("FAIL rd_c3 busy/in/done got %b want 001", {io_busy, in_signal, io_done}); end
    if (sb_q.size() == 0) begin
      n_cmp++; n_bad++; $display("FAIL rd_sb_empty got 0 entries want 1");
    end else begin
      e = sb_q.pop_front();
      n_cmp++; if ((e.is_rd ? rd_data : dev_wr_data) !== e.data) begin n_bad++; $display("FAIL rd_data got %h want %h", rd_data, e.data); end
      n_cmp++; if (io_timeout !== e.to) begin n_bad++; $display("FAIL rd_timeout got %b want %b", io_timeout, e.to); end
    end
    io_rd = 1'b0;
    step();
    n_cmp++; if ({io_done, in_signal} !== 2'b00) begin n_bad++; $display("FAIL rd_c4 done/in got %b want 00", {io_done, in_signal}); end
  endtask

  task automatic test_write();
    exp_t e;
    wr_data = 8'h3C;
    sb_q.push_back({1'b0, 1'b0, 8'h3C});
    io_wr = 1'b1;
    #1;
    n_cmp++; if ({io_busy, out_signal} !== 2'b10) begin n_bad++; $display("FAIL wr_c0 busy/out got %b want 10", {io_busy, out_signal}); end
    step();
    wr_data = 8'h00;
    n_cmp++; if ({out_signal, in_signal} !== 2'b10) begin n_bad++; $display("FAIL wr_c1 out/in got %b want 10", {out_signal, in_signal}); end
    n_cmp++; if (dev_wr_data !== 8'h3C) begin n_bad++; $display("FAIL wr_c1_dev_wr_data got %h want 3c", dev_wr_data); end
    step();
    n_cmp++; if ({out_signal, io_done} !== 2'b10) begin n_bad++; $display("FAIL wr_c2 out/done got %b want 10", {out_signal, io_done}); end
    step();
    n_cmp++; if ({out_signal, io_done, io_busy} !== 3'b010) begin n_bad++; $display("FAIL wr_c3 out/done/busy got %b want 010", {out_signal, io_done, io_busy}); end
    if (sb_q.size() == 0) begin
      n_cmp++; n_bad++; $display("FAIL wr_sb_empty got 0 entries want 1");
    end else begin
      e = sb_q.pop_front();
      n_cmp++; if ((e.is_rd ? rd_data : dev_wr_data) !== e.data) begin n_bad++; $display("FAIL wr_dev_wr_data got %h want %h", dev_wr_data, e.data); end
    end
    n_cmp++; if (rd_data !== 8'hA5) begin n_bad++; $display("FAIL wr_rd_data_kept got %h want a5", rd_data); end
    io_wr = 1'b0;
    step();
  endtask

  task automatic test_timeout();
    exp_t e;
    int   n_hi;
    int   done_at;
    dev_mute = 1'b1;
    dev_rd_data = 8'h77;
    sb_q.push_back({1'b1, 1'b1, 8'hA5});
    io_rd = 1'b1;
    #1;
    n_hi = 0;
    done_at = 0;
    for (int c = 1; c <= 40 && done_at == 0; c++) begin
      step();
      if (in_signal) n_hi++;
      if (io_done) done_at = c;
    end
    n_cmp++; if (n_hi != 15) begin n_bad++; $display("FAIL to_in_cycles got %0d want 15", n_hi); end
    n_cmp++; if (done_at != 16) begin n_bad++; $display("FAIL to_done_cycle got %0d want 16", done_at); end
    if (sb_q.size() == 0) begin
      n_cmp++; n_bad++; $display("FAIL to_sb_empty got 0 entries want 1");
    end else begin
      e = sb_q.pop_front();
      n_cmp++; if ((e.is_rd ? rd_data : dev_wr_data) !== e.data) begin n_bad++; $display("FAIL to_rd_data got %h want %h", rd_data, e.data); end
      n_cmp++; if (io_timeout !== e.to) begin n_bad++; $display("FAIL to_flag got %b want %b", io_timeout, e.to); end
    end
    io_rd = 1'b0;
    dev_mute = 1'b0;
    step();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    n_cmp++; if (io_timeout !== 1'b0) begin n_bad++; $display("FAIL to_clear got %b want 0", io_timeout); end
  endtask

  task automatic test_timeout_boundary();
    exp_t e;
    int   done_at;
    dev_mute = 1'b1;
    dev_rd_data = 8'hE7;
    sb_q.push_back({1'b1, 1'b0, 8'hE7});
    io_rd = 1'b1;
    #1;
    done_at = 0;
    for (int c = 1; c <= 40 && done_at == 0; c++) begin
      step();
      if (io_done) done_at = c;
      dev_force_in = (c == 14);
    end
    dev_force_in = 1'b0;
    n_cmp++; if (done_at != 16) begin n_bad++; $display("FAIL tb_done_cycle got %0d want 16", done_at); end
    if (sb_q.size() == 0) begin
      n_cmp++; n_bad++; $display("FAIL tb_sb_empty got 0 entries want 1");
    end else begin
      e = sb_q.pop_front();
      n_cmp++; if ((e.is_rd ? rd_data : dev_wr_data) !== e.data) begin n_bad++; $display("FAIL tb_rd_data got %h want %h", rd_data, e.data); end
      n_cmp++; if (io_timeout !== e.to) begin n_bad++; $display("FAIL tb_flag got %b want %b", io_timeout, e.to); end
    end
    io_rd = 1'b0;
    dev_mute = 1'b0;
    step();
  endtask

  task automatic test_collision();
    exp_t e;
    int   cyc;
    wr_data = 8'hFF;
    dev_rd_data = 8'h5A;
    sb_q.push_back({1'b1, 1'b0, 8'h5A});
    io_rd = 1'b1;
    io_wr = 1'b1;
    #1;
    step();
    n_cmp++; if ({in_signal, out_signal} !== 2'b10) begin n_bad++; $display("FAIL col_req got %b want 10", {in_signal, out_signal}); end
    n_cmp++; if (io_collision !== 1'b1) begin n_bad++; $display("FAIL col_flag got %b want 1", io_collision); end
    wait_done(20, cyc);
    n_cmp++; if (cyc != 2) begin n_bad++; $display("FAIL col_done_wait got %0d want 2", cyc); end
    if (sb_q.size() == 0) begin
      n_cmp++; n_bad++; $display("FAIL col_sb_empty got 0 entries want 1");
    end else begin
      e = sb_q.pop_front();
      n_cmp++; if ((e.is_rd ? rd_data : dev_wr_data) !== e.data) begin n_bad++; $display("FAIL col_rd_data got %h want %h", rd_data, e.data); end
    end
    n_cmp++; if (dev_wr_data !== 8'h3C) begin n_bad++; $display("FAIL col_dev_wr_data got %h want 3c", dev_wr_data); end
    io_rd = 1'b0;
    io_wr = 1'b0;
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    n_cmp++; if (io_collision !== 1'b0) begin n_bad++; $display("FAIL col_clear got %b want 0", io_collision); end
  endtask

  task automatic test_abort();
    int n_done;
    dev_rd_data = 8'hC3;
    io_rd = 1'b1;
    #1;
    step();
    n_cmp++; if (in_signal !== 1'b1) begin n_bad++; $display("FAIL ab_c1_in got %b want 1", in_signal); end
    step();
    state = 3'b001;
    step();
    n_cmp++; if ({in_signal, io_done, io_busy} !== 3'b000) begin n_bad++; $display("FAIL ab_c3 in/done/busy got %b want 000", {in_signal, io_done, io_busy}); end
    n_cmp++; if ({io_timeout, io_collision} !== 2'b00) begin n_bad++; $display("FAIL ab_flags got %b want 00", {io_timeout, io_collision}); end
    n_done = 0;
    for (int c = 0; c < 3; c++) begin
      step();
      if (io_done) n_done++;
    end
    n_cmp++; if (n_done != 0) begin n_bad++; $display("FAIL ab_no_done got %0d want 0", n_done); end
    n_cmp++; if (rd_data !== 8'h5A) begin n_bad++; $display("FAIL ab_rd_data got %h want 5a", rd_data); end
    io_rd = 1'b0;
    state = 3'b010;
    step();
  endtask

  task automatic test_reset_mid_write();
    exp_t e;
    int   cyc;
    wr_data = 8'h99;
    io_wr = 1'b1;
    #1;
    step();
    step();
    n_cmp++; if (out_signal !== 1'b1) begin n_bad++; $display("FAIL rs_out_before got %b want 1", out_signal); end
    reset = 1'b1;
    io_wr = 1'b0;
    step();
    n_cmp++; if ({out_signal, in_signal, io_done} !== 3'b000) begin n_bad++; $display("FAIL rs_req got %b want 000", {out_signal, in_signal, io_done}); end
    n_cmp++; if ({rd_data, dev_wr_data} !== 16'h0000) begin n_bad++; $display("FAIL rs_data got %h want 0000", {rd_data, dev_wr_data}); end
    reset = 1'b0;
    dev_rd_data = 8'h42;
    sb_q.push_back({1'b1, 1'b0, 8'h42});
    io_rd = 1'b1;
    wait_done(20, cyc);
    n_cmp++; if (cyc != 3) begin n_bad++; $display("FAIL rs_rd_latency got %0d want 3", cyc); end
    if (sb_q.size() == 0) begin
      n_cmp++; n_bad++; $display("FAIL rs_sb_empty got 0 entries want 1");
    end else begin
      e = sb_q.pop_front();
      n_cmp++; if ((e.is_rd ? rd_data : dev_wr_data) !== e.data) begin n_bad++; $display("FAIL rs_rd_data got %h want %h", rd_data, e.data); end
    end
    io_rd = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_timeout();
    test_timeout_boundary();
    test_collision();
    test_abort();
    test_reset_mid_write();
    n_cmp++; if (sb_q.size() != 0) begin n_bad++; $display("FAIL sb_leftover got %0d want 0", sb_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/io_requester.md
# io_requester

CPU-side initiator for the I/O handshake. It converts the CPU's execute-stage I/O read and write requests into level-held `in_signal`/`out_signal` requests toward the I/O device, then waits for the device's registered `clocked_in_signal`/`clocked_out_signal` acknowledge. While a transfer is open it stalls the CPU. It captures read data, holds write data stable, bounds every wait with a timeout, and reports completion with a one-cycle pulse.

## Interface
- `DATA_W`, default 8, width of read and write data.
- `TIMEOUT_CYCLES`, default 15, maximum number of WAIT cycles before a transfer is abandoned; legal range ≥2.
- `clk`  in  1  clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `state`  in  3  CPU FSM state; I/O is legal only when `state == 3'b010` (execute).
- `io_rd`  in  1  CPU requests an input transfer; held high until `io_done`.
- `io_wr`  in  1  CPU requests an output transfer; held high until `io_done`.
- `wr_data`  in  DATA_W  CPU write data; sampled when a request is accepted.
- `in_signal`  out  1  input request to the device.
- `out_signal`  out  1  output request to the device.
- `clocked_in_signal`  in  1  device acknowledge for input.
- `clocked_out_signal`  in  1  device acknowledge for output.
- `dev_rd_data`  in  DATA_W  device read data; valid in the cycle `clocked_in_signal` is high.
- `dev_wr_data`  out  DATA_W  latched write data presented to the device.
- `rd_data`  out  DATA_W  captured read data.
- `io_busy`  out  1  stalls the CPU.
- `io_done`  out  1  one-cycle completion pulse.
- `io_timeout`  out  1  sticky; a transfer was abandoned without an acknowledge.
- `io_collision`  out  1  sticky; `io_rd` and `io_wr` were both high at acceptance.
- `err_clr`  in  1  clears both sticky flags.

## Operation
FSM states are IDLE, WAIT_IN, WAIT_OUT and COMPLETE.
- **IDLE → WAIT_IN:** taken when `state == 3'b010 && io_rd`.
- **IDLE → WAIT_OUT:** taken when `state == 3'b010 && io_wr && !io_rd`.
  - On acceptance, `wr_data` is latched into `dev_wr_data`.
- **Simultaneous `io_rd` and `io_wr`:** the read is served, the write is dropped, and `io_collision` is set.
- **Request lines:** `in_signal` is high exactly in WAIT_IN; `out_signal` is high exactly in WAIT_OUT. Both are registered state decodes and never glitch.
- **WAIT_IN:**
  - `clocked_in_signal` high → `rd_data <= dev_rd_data`, then go to COMPLETE.
  - `clocked_out_signal` is ignored.
- **WAIT_OUT:**
  - `clocked_out_signal` high → go to COMPLETE.
  - `clocked_in_signal` is ignored.
- **Timeout counter:**
  - Width is $clog2(TIMEOUT_CYCLES+1). It clears on entry to either WAIT state and increments each WAIT cycle.
  - If the counter reaches TIMEOUT_CYCLES-1 without an acknowledge: set `io_timeout`, leave `rd_data` unchanged, go to COMPLETE.
  - An acknowledge in that same cycle wins: normal completion, no timeout.
- **Abort:** if `state != 3'b010` during a WAIT state, go to IDLE on the next edge. There is no `io_done`, no data capture and no flag.
- **COMPLETE:** `io_done = 1`, then go to IDLE unconditionally. Requests seen in COMPLETE are ignored.
- **`io_busy`:** equals (WAIT_IN | WAIT_OUT) | (IDLE & `state == 3'b010` & (`io_rd` | `io_wr`)). This is combinational, so the request cycle itself stalls.
- **Sticky flags:** `err_clr` has priority over a set in the same cycle.
- **Reset:** FSM = IDLE, counter = 0, and every output is 0 (`in_signal`, `out_signal`, `rd_data`, `dev_wr_data`, `io_done`, `io_timeout`, `io_collision`, and `io_busy` when no request is pending). Reset asserted mid-transfer returns to IDLE on the next edge and drops the request line.

## Timing
Cycle 0 below is the cycle in which the request is first seen while `state == 3'b010`.
- **Read with a responsive device:**
  - Cycle 0: `io_busy` = 1.
  - Cycle 1: `in_signal` = 1.
  - Cycle 2: the device drives the acknowledge.
  - Cycle 3: COMPLETE; `rd_data` valid, `io_done` = 1, `io_busy` = 0.
  - Cycle 4: IDLE.
- **Write:** same timing, with `out_signal` high in cycles 1–2.
- **Request-to-done latency:** 3 cycles minimum; TIMEOUT_CYCLES+1 cycles maximum.
- **Trailing acknowledge:** the device's acknowledge stays high for one cycle after the request drops (cycle 3). It is ignored because the FSM is in COMPLETE. A new request accepted in cycle 4 sees a clean low acknowledge.
- **Back-to-back transfers:** minimum spacing is 4 cycles.
- **Data stability:** `dev_wr_data` is stable from cycle 1 until the next accepted write.

## Test plan
1. **Read:** `state = 010`, `io_rd` pulsed and held, device model acks after 1 cycle with `dev_rd_data = 8'hA5` → `in_signal` high in cycles 1–2, `rd_data = 8'hA5` and `io_done` in cycle 3, `io_busy` high in cycles 0–2.
2. **Write:** `io_wr` with `wr_data = 8'h3C` → `out_signal` high in cycles 1–2, `dev_wr_data = 8'h3C` from cycle 1, `io_done` in cycle 3, `rd_data` unchanged.
3. **Timeout:** device never acks, `TIMEOUT_CYCLES = 15` → `in_signal` high for 15 cycles, `io_timeout = 1`, `io_done` in cycle 16, `rd_data` retains its prior value; then `err_clr` → `io_timeout = 0`.
4. **Collision:** `io_rd = io_wr = 1` with `wr_data = 8'hFF` → only `in_signal` is raised, `io_collision = 1`, `dev_wr_data` not updated.
5. **Abort:** `state` changes to `3'b001` in cycle 2 of WAIT_IN → IDLE next cycle, no `io_done`, `in_signal` drops, all flags 0.
6. **Reset mid-WAIT_OUT, then immediate read:** reset drops `out_signal` and clears all outputs. A read issued right after reset completes with the correct `rd_data` and is not falsely acknowledged by the stale device acknowledge.
